// File: rtl/tm_pkg.sv
// Shared constants and types for the 6510 on-chip I/O port emulation.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tm_pkg;

   // CPU addresses of the two port registers
   localparam logic [15:0] ADDR_DDR  = 16'h0000;
   localparam logic [15:0] ADDR_DATA = 16'h0001;

   // Port bit assignments
   localparam int BIT_LORAM      = 0;
   localparam int BIT_HIRAM      = 1;
   localparam int BIT_CHAREN     = 2;
   localparam int BIT_CASS_SENSE = 4;

   // Register reset values
   localparam logic [7:0] DDR_RST  = 8'h00;
   localparam logic [7:0] DATA_RST = 8'h00;

   // Register pair: direction register and output latch
   typedef struct packed {
      logic [7:0] ddr;
      logic [7:0] data;
   } port_regs_t;

   // A pin with a pull-up: driven value when the DDR bit is set, else 1
   function automatic logic pulled_up(input logic ddr_bit, input logic data_bit);
      return ddr_bit ? data_bit : 1'b1;
   endfunction

endpackage

// File: rtl/port_fade.sv
// Capacitive fade of one undriven port bit: reads 1 for FADE_CYCLES clk after last driven high.
// Latency: level reflects a new drive state 1 clk after it appears on the inputs.
// Backpressure: none; free-running counter.
module port_fade #(
   parameter int FADE_CYCLES = 350000,
   parameter int FADE_W      = $clog2(FADE_CYCLES + 1)
) (
   input  logic clk,
   input  logic _reset,
   input  logic drive_hi,
   input  logic drive_lo,
   input  logic floating,
   output logic level
);

   logic [FADE_W-1:0] cnt;

   // Load on drive-high, clear on drive-low, bleed down while floating
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         cnt <= '0;
      end else if (drive_hi) begin
         cnt <= FADE_W'(FADE_CYCLES);
      end else if (drive_lo) begin
         cnt <= '0;
      end else if (floating && (cnt != '0)) begin
         cnt <= cnt - FADE_W'(1);
      end
   end

   assign level = (cnt != '0);

endmodule

// File: rtl/cpu_port.sv
// 6510 on-chip I/O port: DDR ($0000) and DATA ($0001) with banking, pin drive and read-back.
// Latency: a write commits on the strobe's rising edge and shows on outputs 1 clk later; reads are combinational.
// Backpressure: none; strobes are accepted every clk. Bit 6/7 fade model built only with TURBO_PORT_FADE_EN.
module cpu_port
   import tm_pkg::*;
#(
   parameter int FADE_CYCLES = 350000,
   parameter int FADE_W      = $clog2(FADE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       _wr0000,
   input  logic       _wr0001,
   input  logic       _rd0001,
   input  logic       a0,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   input  logic [7:0] pin_in,
   output logic [7:0] port_out,
   output logic [7:0] port_oe,
   output logic       loram,
   output logic       hiram,
   output logic       charen
);

   port_regs_t regs;
   port_regs_t shadow;
   logic       wr0_q;
   logic       wr1_q;
   logic [1:0] hi_view;
   logic [7:0] pin_view;

   // Capture write data while a strobe is low; remember last strobe level for edge detect.
   // Edge flops reset high so a strobe caught low by reset never produces a commit.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         shadow <= '1;
         wr0_q  <= 1'b1;
         wr1_q  <= 1'b1;
      end else begin
         if (!_wr0000) shadow.ddr  <= d_in;
         if (!_wr0001) shadow.data <= d_in;
         wr0_q <= _wr0000;
         wr1_q <= _wr0001;
      end
   end

   // Commit shadow into the architectural register on each strobe's rising edge
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         regs.ddr  <= DDR_RST;
         regs.data <= DATA_RST;
      end else begin
         if (!wr0_q && _wr0000) regs.ddr  <= shadow.ddr;
         if (!wr1_q && _wr0001) regs.data <= shadow.data;
      end
   end

   assign port_out = regs.data;
   assign port_oe  = regs.ddr;
   assign loram    = pulled_up(regs.ddr[BIT_LORAM],  regs.data[BIT_LORAM]);
   assign hiram    = pulled_up(regs.ddr[BIT_HIRAM],  regs.data[BIT_HIRAM]);
   assign charen   = pulled_up(regs.ddr[BIT_CHAREN], regs.data[BIT_CHAREN]);
   assign d_oe     = ~_rd0001;

`ifdef TURBO_PORT_FADE_EN
   // Undriven bits 6/7 hold their last high level for a while, like the real chip
   for (genvar g = 0; g < 2; g++) begin : g_fade
      port_fade #(
         .FADE_CYCLES (FADE_CYCLES),
         .FADE_W      (FADE_W)
      ) u_fade (
         .clk      (clk),
         ._reset   (_reset),
         .drive_hi (regs.ddr[6+g] &  regs.data[6+g]),
         .drive_lo (regs.ddr[6+g] & ~regs.data[6+g]),
         .floating (~regs.ddr[6+g]),
         .level    (hi_view[g])
      );
   end
   // External bits 6/7 are not observed when the fade model stands in for them
   logic unused_pins;
   assign unused_pins = ^pin_in[7:6];
`else
   assign hi_view = pin_in[7:6];
   logic unused_fade;
   assign unused_fade = ^{FADE_CYCLES, FADE_W};
`endif

   logic unused_cfg;
   assign unused_cfg = ^{ADDR_DDR, ADDR_DATA, pin_in[BIT_CASS_SENSE]};

   // Read mux: DDR, or per-bit driven value / pin view (pull-ups on bits 0..2)
   always_comb begin
      pin_view      = {hi_view, pin_in[5:0]};
      pin_view[2:0] = pin_in[2:0] | ~regs.ddr[2:0];
      if (a0) begin
         d_out = (regs.ddr & regs.data) | (~regs.ddr & pin_view);
      end else begin
         d_out = regs.ddr;
      end
   end

endmodule

// File: tb/tb_cpu_port.sv
module tb_cpu_port;

   typedef struct packed {
      logic [7:0] d;
      logic [7:0] po;
      logic [7:0] oe;
      logic       lo;
      logic       hi;
      logic       ch;
   } obs_t;

   // Expected read-back of bits 7:6 depends on whether the fade model is built (pin_in = 8'h4A)
`ifdef TURBO_PORT_FADE_EN
   localparam logic [7:0] T2_PINS = 8'h25;
   localparam logic [7:0] T2_CASS = 8'h35;
   localparam logic [7:0] FADE_HI = 8'hCF;
   localparam logic [7:0] FADE_LO = 8'h0F;
`else
   localparam logic [7:0] T2_PINS = 8'h65;
   localparam logic [7:0] T2_CASS = 8'hF5;
   localparam logic [7:0] FADE_HI = 8'h4F;
   localparam logic [7:0] FADE_LO = 8'h4F;
`endif

   logic       clk = 1'b0;
   logic       _reset;
   logic       _wr0000;
   logic       _wr0001;
   logic       _rd0001;
   logic       a0;
   logic [7:0] d_in;
   logic [7:0] d_out;
   logic       d_oe;
   logic [7:0] pin_in;
   logic [7:0] port_out;
   logic [7:0] port_oe;
   logic       loram;
   logic       hiram;
   logic       charen;

   int    checks = 0;
   int    passes = 0;
   obs_t  exp_q[$];
   string name_q[$];

   cpu_port #(.FADE_CYCLES(16)) dut (
      .clk      (clk),
      ._reset   (_reset),
      ._wr0000  (_wr0000),
      ._wr0001  (_wr0001),
      ._rd0001  (_rd0001),
      .a0       (a0),
      .d_in     (d_in),
      .d_out    (d_out),
      .d_oe     (d_oe),
      .pin_in   (pin_in),
      .port_out (port_out),
      .port_oe  (port_oe),
      .loram    (loram),
      .hiram    (hiram),
      .charen   (charen)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [7:0] d, input logic [7:0] po, input logic [7:0] oe,
                               input logic lo, input logic hi, input logic ch);
      obs_t o;
      o.d = d; o.po = po; o.oe = oe; o.lo = lo; o.hi = hi; o.ch = ch;
      return o;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %h expected %h", nm, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold the selected strobe(s) low for n clk with value v, then release and wait one clk
   task automatic wr(input logic sel_ddr, input logic sel_data, input logic [7:0] v, input int n);
      d_in = v;
      if (sel_ddr)  _wr0000 = 1'b0;
      if (sel_data) _wr0001 = 1'b0;
      repeat (n) tick();
      _wr0000 = 1'b1;
      _wr0001 = 1'b1;
      tick();
   endtask

   // One-clk read; the expected observation goes to the scoreboard
   task automatic rd(input string nm, input logic sel, input obs_t e);
      a0 = sel;
      _rd0001 = 1'b0;
      exp_q.push_back(e);
      name_q.push_back(nm);
      tick();
      _rd0001 = 1'b1;
   endtask

   // Monitor: whenever the DUT drives the bus, compare every output against the next expectation
   always @(negedge clk) begin
      if (d_oe === 1'b1) begin
         obs_t  act;
         obs_t  e;
         string nm;
         act = mk(d_out, port_out, port_oe, loram, hiram, charen);
         checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_read: got %h expected no read", act);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (act === e) passes++;
            else $display("FAIL %s: got %h expected %h (d,po,oe,lo,hi,ch)", nm, act, e);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      _reset  = 1'b0;
      _wr0000 = 1'b1;
      _wr0001 = 1'b1;
      _rd0001 = 1'b1;
      a0      = 1'b0;
      d_in    = 8'h00;
      pin_in  = 8'h4A;
      repeat (2) tick();

      // Reset state
      check("rst_d_oe",     32'(d_oe),     32'(0));
      check("rst_port_oe",  32'(port_oe),  32'h00);
      check("rst_port_out", 32'(port_out), 32'h00);
      check("rst_banking",  32'({loram, hiram, charen}), 32'b111);
      _reset = 1'b1;
      tick();

      // 1: no writes
      rd("t1_ddr", 1'b0, mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1));

      // 2: DDR=0x2F (long strobe), DATA=0x35 (single clk)
      wr(1'b1, 1'b0, 8'h2F, 3);
      wr(1'b0, 1'b1, 8'h35, 1);
      tick();
      rd("t2_ddr",  1'b0, mk(8'h2F,   8'h35, 8'h2F, 1'b1, 1'b0, 1'b1));
      rd("t2_pins", 1'b1, mk(T2_PINS, 8'h35, 8'h2F, 1'b1, 1'b0, 1'b1));
      pin_in = 8'hFF;
      rd("t2_cass", 1'b1, mk(T2_CASS, 8'h35, 8'h2F, 1'b1, 1'b0, 1'b1));
      pin_in = 8'h4A;

      // 3: both strobes rise together
      wr(1'b1, 1'b1, 8'hFF, 2);
      rd("t3_ddr",  1'b0, mk(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1));
      rd("t3_data", 1'b1, mk(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1));

      // Single-clk strobes
      wr(1'b1, 1'b0, 8'h07, 1);
      rd("sc_ddr",  1'b0, mk(8'h07, 8'hFF, 8'h07, 1'b1, 1'b1, 1'b1));
      wr(1'b0, 1'b1, 8'h07, 1);
      rd("sc_data", 1'b0, mk(8'h07, 8'h07, 8'h07, 1'b1, 1'b1, 1'b1));

      // 4: reset arrives while the DATA strobe is low; strobe rises at release
      d_in    = 8'h55;
      _wr0001 = 1'b0;
      repeat (2) tick();
      _reset = 1'b0;
      tick();
      check("t4_in_reset_port_out", 32'(port_out), 32'h00);
      check("t4_in_reset_port_oe",  32'(port_oe),  32'h00);
      _reset  = 1'b1;
      _wr0001 = 1'b1;
      repeat (2) tick();
      rd("t4_no_commit", 1'b0, mk(8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1));

      // 5: fade of bits 7/6
      wr(1'b1, 1'b0, 8'hC0, 1);
      wr(1'b0, 1'b1, 8'hC0, 1);
      rd("t5_driven", 1'b1, mk(8'hCF, 8'hC0, 8'hC0, 1'b1, 1'b1, 1'b1));
      wr(1'b1, 1'b0, 8'h00, 1);
      for (int k = 1; k <= 7; k++)
         rd("t5_fade_a", 1'b1, mk(FADE_HI, 8'hC0, 8'h00, 1'b1, 1'b1, 1'b1));
      wr(1'b1, 1'b0, 8'hC0, 1);
      rd("t5_redrive", 1'b1, mk(8'hCF, 8'hC0, 8'hC0, 1'b1, 1'b1, 1'b1));
      wr(1'b1, 1'b0, 8'h00, 1);
      for (int k = 1; k <= 18; k++)
         rd((k <= 16) ? "t5_fade_hi" : "t5_fade_lo", 1'b1,
            mk((k <= 16) ? FADE_HI : FADE_LO, 8'hC0, 8'h00, 1'b1, 1'b1, 1'b1));

      // Driving the bits low clears any pending fade
      wr(1'b1, 1'b0, 8'hC0, 1);
      wr(1'b0, 1'b1, 8'h00, 1);
      wr(1'b1, 1'b0, 8'h00, 1);
      rd("t5_drive_lo", 1'b1, mk(FADE_LO, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1));

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
